// File: rtl/sad_wb_pkg.sv
// Shared types and constants for the MIPS+SAD writeback stage.
package sad_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sad_state_e;

  localparam logic [2:0] MTR_ALU = 3'd0;
  localparam logic [2:0] MTR_MEM = 3'd1;
  localparam logic [2:0] MTR_PC4 = 3'd2;
  localparam logic [2:0] MTR_HI  = 3'd3;
  localparam logic [2:0] MTR_LO  = 3'd4;
  localparam logic [2:0] MTR_SAD = 3'd5;

  localparam int NUM_PAIRS = 8;

endpackage

// File: rtl/sad_writeback_stage_if.sv
// MEM/WB-to-register-file bus of the writeback stage; master drives the
// pipeline-register side, slave is the writeback stage itself.
interface sad_writeback_stage_if
  import sad_wb_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                           iSAD;
  logic                           iRegWriteCtrl;
  logic                           iMove;
  logic                           iZero;
  logic [2:0]                     iMemToReg;
  logic [DATA_W-1:0]              iPCPlus4;
  logic [DATA_W-1:0]              iALUResult;
  logic [DATA_W-1:0]              iMemReadData;
  logic [DATA_W-1:0]              iHi;
  logic [DATA_W-1:0]              iLo;
  logic [4:0]                     iRegDstResult;
  logic [2*DATA_W-1:0]            iHiLoResult;
  logic                           iHiLoWrite;
  logic [NUM_PAIRS*DATA_W-1:0]    iPairA;
  logic [NUM_PAIRS*DATA_W-1:0]    iPairB;

  logic                           oRegWrite;
  logic [4:0]                     oWriteReg;
  logic [DATA_W-1:0]              oWriteData;
  logic                           oHiLoWrite;
  logic [2*DATA_W-1:0]            oHiLoData;
  logic                           Stall;
  logic                           oSADBusy;

  modport master (
    output iSAD, iRegWriteCtrl, iMove, iZero, iMemToReg,
           iPCPlus4, iALUResult, iMemReadData, iHi, iLo,
           iRegDstResult, iHiLoResult, iHiLoWrite, iPairA, iPairB,
    input  oRegWrite, oWriteReg, oWriteData, oHiLoWrite, oHiLoData,
           Stall, oSADBusy
  );

  modport slave (
    input  iSAD, iRegWriteCtrl, iMove, iZero, iMemToReg,
           iPCPlus4, iALUResult, iMemReadData, iHi, iLo,
           iRegDstResult, iHiLoResult, iHiLoWrite, iPairA, iPairB,
    output oRegWrite, oWriteReg, oWriteData, oHiLoWrite, oHiLoData,
           Stall, oSADBusy
  );

endinterface

// File: rtl/sad_lane_adder.sv
// Adds |A-B| of LANES operand pairs to the running SAD sum in one cycle.
// SAD_SATURATE_EN makes the sum stick at all-ones instead of wrapping.
module sad_lane_adder
  import sad_wb_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DATA_W = 32
) (
  input  logic [LANES*DATA_W-1:0] i_a,
  input  logic [LANES*DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0]       i_acc,
  output logic [DATA_W-1:0]       o_acc
);

  logic [DATA_W-1:0] w_sum;

  always_comb begin
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] diff;
`ifdef SAD_SATURATE_EN
    logic [DATA_W:0]   ext;
    ext   = '0;
`endif
    w_sum = i_acc;
    a     = '0;
    b     = '0;
    diff  = '0;
    for (int l = 0; l < LANES; l++) begin
      a    = i_a[l*DATA_W +: DATA_W];
      b    = i_b[l*DATA_W +: DATA_W];
      diff = (a >= b) ? (a - b) : (b - a);
`ifdef SAD_SATURATE_EN
      // Once saturated, any further add carries out or lands on all-ones again.
      ext   = {1'b0, w_sum} + {1'b0, diff};
      w_sum = ext[DATA_W] ? '1 : ext[DATA_W-1:0];
`else
      w_sum = w_sum + diff;
`endif
    end
  end

  assign o_acc = w_sum;

endmodule

// File: rtl/sad_writeback_stage.sv
// Writeback stage of the MIPS+SAD pipeline: result mux plus multi-cycle SAD
// engine that stalls MEM/WB. Optional macro SAD_SATURATE_EN saturates the SAD sum.
module sad_writeback_stage
  import sad_wb_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DATA_W = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sad_writeback_stage_if.slave  bus
);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_lanesCheck
    $error("sad_writeback_stage: LANES must be 1, 2, 4 or 8");
  end

  localparam logic [3:0] LANES_C = 4'(LANES);
  localparam logic [3:0] PAIRS_C = 4'(NUM_PAIRS);

  sad_state_e                  r_state;
  sad_state_e                  w_nextState;
  logic                        w_stallRaw;
  logic                        r_busy;
  logic [3:0]                  r_cnt;
  logic [3:0]                  w_cntNext;
  logic [DATA_W-1:0]           r_acc;
  logic [DATA_W-1:0]           w_accNext;
  logic [NUM_PAIRS*DATA_W-1:0] r_pairA;
  logic [NUM_PAIRS*DATA_W-1:0] r_pairB;
  logic [4:0]                  r_capDst;
  logic                        r_capRegWrite;
  logic [LANES*DATA_W-1:0]     w_laneA;
  logic [LANES*DATA_W-1:0]     w_laneB;
  logic [DATA_W-1:0]           w_wbSel;
  logic                        r_regWrite;
  logic [4:0]                  r_writeReg;
  logic [DATA_W-1:0]           r_writeData;
  logic                        r_hiLoWrite;
  logic [2*DATA_W-1:0]         r_hiLoData;
  int                          w_base;

  assign w_cntNext = r_cnt + LANES_C;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState != IDLE);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_stallRaw  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.iSAD) begin
          w_stallRaw  = 1'b1;
          w_nextState = ACCUM;
        end
      end
      ACCUM: begin
        w_stallRaw = 1'b1;
        if (w_cntNext == PAIRS_C) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // In reset the FSM sits in IDLE, so a held iSAD must not leak through.
  assign bus.Stall = Reset & w_stallRaw;

  assign w_base = int'(r_cnt[2:0]);

  always_comb begin
    w_laneA = '0;
    w_laneB = '0;
    for (int l = 0; l < LANES; l++) begin
      w_laneA[l*DATA_W +: DATA_W] = r_pairA[(w_base + l)*DATA_W +: DATA_W];
      w_laneB[l*DATA_W +: DATA_W] = r_pairB[(w_base + l)*DATA_W +: DATA_W];
    end
  end

  sad_lane_adder #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_laneAdder (
    .i_a   (w_laneA),
    .i_b   (w_laneB),
    .i_acc (r_acc),
    .o_acc (w_accNext)
  );

  always_comb begin
    w_wbSel = bus.iALUResult;
    case (bus.iMemToReg)
      MTR_MEM: w_wbSel = bus.iMemReadData;
      MTR_PC4: w_wbSel = bus.iPCPlus4;
      MTR_HI:  w_wbSel = bus.iHi;
      MTR_LO:  w_wbSel = bus.iLo;
      MTR_SAD: w_wbSel = r_acc;
      default: w_wbSel = bus.iALUResult;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_pairA       <= '0;
      r_pairB       <= '0;
      r_capDst      <= '0;
      r_capRegWrite <= 1'b0;
      r_regWrite    <= 1'b0;
      r_writeReg    <= '0;
      r_writeData   <= '0;
      r_hiLoWrite   <= 1'b0;
      r_hiLoData    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.iSAD) begin
            r_pairA       <= bus.iPairA;
            r_pairB       <= bus.iPairB;
            r_capDst      <= bus.iRegDstResult;
            r_capRegWrite <= bus.iRegWriteCtrl;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_regWrite    <= 1'b0;
            r_hiLoWrite   <= 1'b0;
          end else begin
            r_regWrite  <= bus.iRegWriteCtrl & (~bus.iMove | ~bus.iZero);
            r_writeReg  <= bus.iRegDstResult;
            r_writeData <= w_wbSel;
            r_hiLoWrite <= bus.iHiLoWrite;
            r_hiLoData  <= bus.iHiLoResult;
          end
        end
        ACCUM: begin
          r_acc <= w_accNext;
          r_cnt <= w_cntNext;
        end
        DONE: begin
          r_regWrite  <= r_capRegWrite;
          r_writeReg  <= r_capDst;
          r_writeData <= r_acc;
          r_hiLoWrite <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.oRegWrite  = r_regWrite;
  assign bus.oWriteReg  = r_writeReg;
  assign bus.oWriteData = r_writeData;
  assign bus.oHiLoWrite = r_hiLoWrite;
  assign bus.oHiLoData  = r_hiLoData;
  assign bus.oSADBusy   = r_busy;

endmodule

// File: tb/tb_sad_writeback_stage.sv
// Scoreboard bench for sad_writeback_stage: a LANES=1 and a LANES=8 instance
// share one instruction stream; one of them is observed at a time.
module tb_sad_writeback_stage;
  import sad_wb_pkg::*;

  typedef struct {
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        hiLoWrite;
    logic [63:0] hiLoData;
  } wbExp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic         sadIn = 0, regWriteCtrlIn = 0, moveIn = 0, zeroIn = 0, hiLoWrIn = 0;
  logic [2:0]   memToRegIn = 0;
  logic [31:0]  aluV = 0, memV = 0, pc4V = 0, hiV = 0, loV = 0;
  logic [4:0]   dstIn = 0;
  logic [63:0]  hiLoResIn = 0;
  logic [255:0] pairAIn = 0, pairBIn = 0;

  bit           useWide = 0;
  int           assertCount = 0;
  int           failCount = 0;
  wbExp_t       expQ[$];
  logic [31:0]  lastSad = 0;
  logic [63:0]  lastHiLo = 0;

  sad_writeback_stage_if busNarrow ();
  sad_writeback_stage_if busWide ();

  assign busNarrow.iSAD = sadIn;          assign busWide.iSAD = sadIn;
  assign busNarrow.iRegWriteCtrl = regWriteCtrlIn; assign busWide.iRegWriteCtrl = regWriteCtrlIn;
  assign busNarrow.iMove = moveIn;        assign busWide.iMove = moveIn;
  assign busNarrow.iZero = zeroIn;        assign busWide.iZero = zeroIn;
  assign busNarrow.iMemToReg = memToRegIn; assign busWide.iMemToReg = memToRegIn;
  assign busNarrow.iPCPlus4 = pc4V;       assign busWide.iPCPlus4 = pc4V;
  assign busNarrow.iALUResult = aluV;     assign busWide.iALUResult = aluV;
  assign busNarrow.iMemReadData = memV;   assign busWide.iMemReadData = memV;
  assign busNarrow.iHi = hiV;             assign busWide.iHi = hiV;
  assign busNarrow.iLo = loV;             assign busWide.iLo = loV;
  assign busNarrow.iRegDstResult = dstIn; assign busWide.iRegDstResult = dstIn;
  assign busNarrow.iHiLoResult = hiLoResIn; assign busWide.iHiLoResult = hiLoResIn;
  assign busNarrow.iHiLoWrite = hiLoWrIn; assign busWide.iHiLoWrite = hiLoWrIn;
  assign busNarrow.iPairA = pairAIn;      assign busWide.iPairA = pairAIn;
  assign busNarrow.iPairB = pairBIn;      assign busWide.iPairB = pairBIn;

  sad_writeback_stage #(.LANES(1), .DATA_W(32)) dutNarrow (
    .Clk(Clk), .Reset(Reset), .bus(busNarrow)
  );

  sad_writeback_stage #(.LANES(8), .DATA_W(32)) dutWide (
    .Clk(Clk), .Reset(Reset), .bus(busWide)
  );

  logic        obsStall, obsBusy, obsRegWrite, obsHiLoWrite;
  logic [4:0]  obsWriteReg;
  logic [31:0] obsWriteData;
  logic [63:0] obsHiLoData;

  assign obsStall     = useWide ? busWide.Stall      : busNarrow.Stall;
  assign obsBusy      = useWide ? busWide.oSADBusy   : busNarrow.oSADBusy;
  assign obsRegWrite  = useWide ? busWide.oRegWrite  : busNarrow.oRegWrite;
  assign obsHiLoWrite = useWide ? busWide.oHiLoWrite : busNarrow.oHiLoWrite;
  assign obsWriteReg  = useWide ? busWide.oWriteReg  : busNarrow.oWriteReg;
  assign obsWriteData = useWide ? busWide.oWriteData : busNarrow.oWriteData;
  assign obsHiLoData  = useWide ? busWide.oHiLoData  : busNarrow.oHiLoData;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelSel(input logic [2:0] mtr);
    case (mtr)
      3'd1:    return memV;
      3'd2:    return pc4V;
      3'd3:    return hiV;
      3'd4:    return loV;
      3'd5:    return lastSad;
      default: return aluV;
    endcase
  endfunction

  function automatic logic [31:0] sadModel(input logic [255:0] a, input logic [255:0] b);
    logic [63:0] total;
    logic [31:0] x, y;
    total = 64'd0;
    for (int k = 0; k < 8; k++) begin
      x = a[32*k +: 32];
      y = b[32*k +: 32];
      total = total + ((x > y) ? (64'(x) - 64'(y)) : (64'(y) - 64'(x)));
    end
`ifdef SAD_SATURATE_EN
    return (total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : total[31:0];
`else
    return total[31:0];
`endif
  endfunction

  task automatic randomizeSources();
    aluV = $urandom; memV = $urandom; pc4V = $urandom; hiV = $urandom; loV = $urandom;
  endtask

  // Call aligned to a falling edge; returns aligned to a falling edge.
  task automatic applyStimulus(input bit sad, input logic [2:0] mtr, input logic [4:0] dst,
                               input logic ctrl, input logic move, input logic zero,
                               input logic hlw, input logic [63:0] hlr);
    wbExp_t e;
    int     stallCnt;
    int     expStall;
    bit     accepted;
    sadIn = sad; memToRegIn = mtr; dstIn = dst; regWriteCtrlIn = ctrl;
    moveIn = move; zeroIn = zero; hiLoWrIn = hlw; hiLoResIn = hlr;
    if (sad) begin
      e.writeData = sadModel(pairAIn, pairBIn);
      e.regWrite  = ctrl;
      e.writeReg  = dst;
      e.hiLoWrite = 1'b0;
      e.hiLoData  = lastHiLo;
      lastSad     = e.writeData;
      expStall    = 1 + NUM_PAIRS / (useWide ? 8 : 1);
    end else begin
      e.writeData = modelSel(mtr);
      e.regWrite  = ctrl & (~move | ~zero);
      e.writeReg  = dst;
      e.hiLoWrite = hlw;
      e.hiLoData  = hlr;
      lastHiLo    = hlr;
      expStall    = 0;
    end
    expQ.push_back(e);
    stallCnt = 0;
    accepted = 0;
    for (int c = 0; c < 40 && !accepted; c++) begin
      #1;
      if (!obsStall) begin
        accepted = 1;
      end else begin
        if (stallCnt == 1) begin
          pairAIn = pairAIn ^ {8{32'hA5A5_5A5A}};
          pairBIn = pairBIn ^ {8{32'h0F0F_F0F0}};
          dstIn   = ~dstIn;
        end
        if (stallCnt > 0) begin
          checkOutput("regWriteDuringStall", obsRegWrite, 0);
          checkOutput("busyDuringStall", obsBusy, 1);
        end
        stallCnt++;
        @(negedge Clk);
      end
    end
    if (!accepted) checkOutput("stallTimeout", 0, 1);
    checkOutput("stallCycles", stallCnt, expStall);
    @(posedge Clk);
    #1;
    e = expQ.pop_front();
    checkOutput("oRegWrite", obsRegWrite, e.regWrite);
    checkOutput("oWriteReg", obsWriteReg, e.writeReg);
    checkOutput("oWriteData", obsWriteData, e.writeData);
    checkOutput("oHiLoWrite", obsHiLoWrite, e.hiLoWrite);
    checkOutput("oHiLoData", obsHiLoData, e.hiLoData);
    if (sad) checkOutput("busyAfterSad", obsBusy, 0);
    @(negedge Clk);
  endtask

  task automatic checkAllCleared(input string tag);
    checkOutput({tag, "RegWrite"}, obsRegWrite, 0);
    checkOutput({tag, "WriteReg"}, obsWriteReg, 0);
    checkOutput({tag, "WriteData"}, obsWriteData, 0);
    checkOutput({tag, "HiLoWrite"}, obsHiLoWrite, 0);
    checkOutput({tag, "HiLoData"}, obsHiLoData, 0);
    checkOutput({tag, "Stall"}, obsStall, 0);
    checkOutput({tag, "Busy"}, obsBusy, 0);
  endtask

  task automatic setRampPairs();
    for (int k = 0; k < 8; k++) begin
      pairAIn[32*k +: 32] = 32'(10 * k);
      pairBIn[32*k +: 32] = 32'(3 * k);
    end
  endtask

  task automatic runSadSuite();
    setRampPairs();
    applyStimulus(1, MTR_SAD, 5'd4, 1, 0, 0, 0, 64'd0);
    checkOutput("sadRampValue", lastSad, 32'h0000_00C4);
    randomizeSources();
    applyStimulus(0, MTR_SAD, 5'd7, 1, 0, 0, 0, 64'h1111_2222_3333_4444);
    randomizeSources();
    applyStimulus(0, MTR_ALU, 5'd8, 0, 0, 0, 0, 64'h0);
    pairAIn = {8{32'hFFFF_FFFF}};
    pairBIn = '0;
    applyStimulus(1, MTR_SAD, 5'd21, 1, 0, 0, 0, 64'd0);
    randomizeSources();
    applyStimulus(0, MTR_LO, 5'd2, 1, 0, 0, 0, 64'h5);
    pairAIn = '0;
    pairBIn = {8{32'hFFFF_FFFF}};
    applyStimulus(1, MTR_SAD, 5'd22, 1, 0, 0, 0, 64'd0);
    randomizeSources();
    applyStimulus(0, MTR_SAD, 5'd23, 1, 0, 0, 0, 64'h6);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] mtrTable [7];
    mtrTable = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

    sadIn = 1;
    repeat (3) @(negedge Clk);
    checkAllCleared("inReset");
    sadIn = 0;
    Reset = 1;
    #1;
    checkAllCleared("afterRelease");
    @(negedge Clk);

    for (int i = 0; i < 7; i++) begin
      randomizeSources();
      if (i == 0) memV = 32'h1234_5678;
      applyStimulus(0, mtrTable[i], (i == 0) ? 5'd9 : 5'(i + 10), 1, 0, 0,
                    logic'(i % 2), {$urandom, $urandom});
    end
    randomizeSources();
    applyStimulus(0, MTR_SAD, 5'd17, 1, 0, 0, 0, 64'hABCD);

    randomizeSources();
    applyStimulus(0, MTR_ALU, 5'd18, 1, 1, 1, 0, 64'h1);
    randomizeSources();
    applyStimulus(0, MTR_ALU, 5'd19, 1, 1, 0, 0, 64'h2);

    runSadSuite();

    randomizeSources();
    applyStimulus(0, MTR_MEM, 5'd30, 1, 0, 0, 1, 64'hDEAD_BEEF_0000_0001);
    #2;
    Reset = 0;
    #1;
    checkAllCleared("asyncReset");
    @(negedge Clk);
    Reset = 1;
    lastSad = 0;
    lastHiLo = 0;

    randomizeSources();
    applyStimulus(0, MTR_HI, 5'd11, 1, 0, 0, 0, 64'h77);
    setRampPairs();
    sadIn = 1; memToRegIn = MTR_SAD; dstIn = 5'd12; regWriteCtrlIn = 1;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    checkOutput("preAbortBusy", obsBusy, 1);
    Reset = 0;
    #1;
    checkOutput("abortStall", obsStall, 0);
    checkOutput("abortBusy", obsBusy, 0);
    checkOutput("abortRegWrite", obsRegWrite, 0);
    sadIn = 0;
    regWriteCtrlIn = 0;
    @(negedge Clk);
    Reset = 1;
    lastSad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checkOutput("noWriteAfterAbort", obsRegWrite, 0);
    end
    randomizeSources();
    applyStimulus(0, MTR_ALU, 5'd3, 1, 0, 0, 0, 64'h99);

    Reset = 0;
    sadIn = 0;
    @(negedge Clk);
    Reset = 1;
    useWide = 1;
    lastSad = 0;
    lastHiLo = 0;
    #1;
    checkAllCleared("wideReset");
    @(negedge Clk);
    randomizeSources();
    applyStimulus(0, MTR_PC4, 5'd25, 1, 0, 0, 1, 64'h1234);
    runSadSuite();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
